// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: raster mode constants and the axis region type
// shared by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz pixel clock, both syncs active-low
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600@60, 40 MHz pixel clock, both syncs active-high
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;
  localparam bit VGA800_HS_POL   = 1'b1;
  localparam bit VGA800_VS_POL   = 1'b1;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } vga_region_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel tick in, raster position/sync/strobes out.
// master = timing generator, slave = pixel pipeline / tick source.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          pix_en;
  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          enable;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          new_line;
  logic          new_frame;

  modport master (
    input  pix_en,
    output h_count, v_count, hsync, vsync,
    output enable, x, y, new_line, new_frame
  );

  modport slave (
    output pix_en,
    input  h_count, v_count, hsync, vsync,
    input  enable, x, y, new_line, new_frame
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: combinational next-count/region/wrap for one axis.
// In: tick, count (current). Out: next, region of next, wrap.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic        tick,
  input  logic [W-1:0] count,
  output logic [W-1:0] next,
  output vga_region_e region,
  output logic        wrap
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START = W'(ACTIVE);
  localparam logic [W-1:0] SY_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START = W'(ACTIVE + FP + SYNC);

  assign wrap = tick && (count == LAST);

  always_comb begin
    next = count;
    if (wrap) begin
      next = '0;
    end else if (tick) begin
      next = count + W'(1);
    end
  end

  // ACTIVE/SYNC parameters shadow the enum names here,
  // hence the package-qualified literals.
  always_comb begin
    region = vga_timing_pkg::BACK;
    unique case (1'b1)
      (next < FP_START):
        region = vga_timing_pkg::ACTIVE;
      (next >= FP_START && next < SY_START):
        region = vga_timing_pkg::FRONT;
      (next >= SY_START && next < BP_START):
        region = vga_timing_pkg::SYNC;
      default:
        region = vga_timing_pkg::BACK;
    endcase
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: registered VGA raster timing for any porch/sync mode.
// Ports: clk, rst (async, active-high), bus (master: pix_en in, timing out).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_mode
    $error("vga_timing_gen: porch and sync widths must be >= 1");
  end

  logic [HW-1:0] h_q, h_d, x_q;
  logic [VW-1:0] v_q, v_d, y_q;
  vga_region_e   h_reg, v_reg;
  logic          h_wrap, v_wrap, v_tick, en_d;
  logic          hsync_q, vsync_q, enable_q;
  logic          line_q, frame_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .W(HW)
  ) u_h (
    .tick(bus.pix_en), .count(h_q), .next(h_d),
    .region(h_reg), .wrap(h_wrap)
  );

  // line advances only on the tick that wraps the line
  assign v_tick = h_wrap & bus.pix_en;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .W(VW)
  ) u_v (
    .tick(v_tick), .count(v_q), .next(v_d),
    .region(v_reg), .wrap(v_wrap)
  );

  assign en_d = (h_reg == ACTIVE) && (v_reg == ACTIVE);

  // all outputs decode the next position so none lag the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q      <= HW'(H_TOTAL - 1);
      v_q      <= VW'(V_TOTAL - 1);
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      enable_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= (h_reg == SYNC) ? HS_POL : ~HS_POL;
      vsync_q  <= (v_reg == SYNC) ? VS_POL : ~VS_POL;
      enable_q <= en_d;
      x_q      <= en_d ? h_d : '0;
      y_q      <= en_d ? v_d : '0;
      line_q   <= h_wrap;
      frame_q  <= h_wrap & v_wrap;
    end
  end

  assign bus.h_count   = h_q;
  assign bus.v_count   = v_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.enable    = enable_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.new_line  = line_q;
  assign bus.new_frame = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 and tiny 7x6 active-high instances
// against a linear pixel-index reference model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  vga_timing_gen_if #(.HW(10), .VW(10)) bus_a ();
  vga_timing_gen_if #(.HW(3), .VW(3)) bus_b ();

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int ha[2]  = '{640, 4};
  int hfp[2] = '{16, 1};
  int hsy[2] = '{96, 1};
  int ht[2]  = '{800, 7};
  int va[2]  = '{480, 3};
  int vfp[2] = '{10, 1};
  int vsy[2] = '{2, 1};
  int vt[2]  = '{525, 6};
  bit pol[2] = '{1'b0, 1'b1};

  int pos[2];
  bit nl[2];
  bit nf[2];
  int frames_b = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset(int m);
    pos[m] = ht[m] * vt[m] - 1;
    nl[m] = 1'b0;
    nf[m] = 1'b0;
  endfunction

  function automatic void mdl_tick(int m, bit en);
    if (en) begin
      pos[m] = (pos[m] + 1) % (ht[m] * vt[m]);
      nl[m] = (pos[m] % ht[m]) == 0;
      nf[m] = pos[m] == 0;
    end else begin
      nl[m] = 1'b0;
      nf[m] = 1'b0;
    end
  endfunction

  task automatic chk_mode(int m, string n,
                          logic [31:0] h, logic [31:0] v,
                          logic [31:0] x, logic [31:0] y,
                          logic hs, logic vs, logic en,
                          logic l, logic f);
    int eh = pos[m] % ht[m];
    int ev = pos[m] / ht[m];
    int hs0 = ha[m] + hfp[m];
    int vs0 = va[m] + vfp[m];
    bit een = (eh < ha[m]) && (ev < va[m]);
    bit in_hs = (eh >= hs0) && (eh < hs0 + hsy[m]);
    bit in_vs = (ev >= vs0) && (ev < vs0 + vsy[m]);
    bit ehs = in_hs ? pol[m] : !pol[m];
    bit evs = in_vs ? pol[m] : !pol[m];
    chk({n, "_h_count"}, h, eh);
    chk({n, "_v_count"}, v, ev);
    chk({n, "_enable"}, 32'(en), 32'(een));
    chk({n, "_x"}, x, een ? eh : 0);
    chk({n, "_y"}, y, een ? ev : 0);
    chk({n, "_hsync"}, 32'(hs), 32'(ehs));
    chk({n, "_vsync"}, 32'(vs), 32'(evs));
    chk({n, "_new_line"}, 32'(l), 32'(nl[m]));
    chk({n, "_new_frame"}, 32'(f), 32'(nf[m]));
  endtask

  task automatic check_all();
    chk_mode(0, "a",
      32'(bus_a.h_count), 32'(bus_a.v_count),
      32'(bus_a.x), 32'(bus_a.y),
      bus_a.hsync, bus_a.vsync, bus_a.enable,
      bus_a.new_line, bus_a.new_frame);
    chk_mode(1, "b",
      32'(bus_b.h_count), 32'(bus_b.v_count),
      32'(bus_b.x), 32'(bus_b.y),
      bus_b.hsync, bus_b.vsync, bus_b.enable,
      bus_b.new_line, bus_b.new_frame);
  endtask

  task automatic step(bit ea, bit eb);
    bus_a.pix_en = ea;
    bus_b.pix_en = eb;
    @(posedge clk);
    #1;
    mdl_tick(0, ea);
    mdl_tick(1, eb);
    check_all();
    if (bus_b.new_frame === 1'b1) frames_b++;
  endtask

  initial begin
    int hs_low;
    int nls;
    int last;
    int cyc;
    bus_a.pix_en = 1'b0;
    bus_b.pix_en = 1'b0;
    rst = 1'b1;
    mdl_reset(0);
    mdl_reset(1);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("a_rst_h", 32'(bus_a.h_count), 799);
    chk("a_rst_v", 32'(bus_a.v_count), 524);
    chk("a_rst_hsync", 32'(bus_a.hsync), 1);
    chk("a_rst_vsync", 32'(bus_a.vsync), 1);
    chk("b_rst_hsync", 32'(bus_b.hsync), 0);
    rst = 1'b0;

    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("a_first_h", 32'(bus_a.h_count), 0);
    chk("a_first_v", 32'(bus_a.v_count), 0);
    chk("a_first_enable", 32'(bus_a.enable), 1);
    chk("a_first_new_line", 32'(bus_a.new_line), 1);
    chk("a_first_new_frame", 32'(bus_a.new_frame), 1);

    // full rate: two lines on A, random ticks on B
    hs_low = 0;
    nls = 0;
    last = -1;
    cyc = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1, 1'($urandom));
      cyc++;
      if (bus_a.hsync === 1'b0) hs_low++;
      if (bus_a.new_line === 1'b1) begin
        if (last >= 0) chk("a_line_period_full", cyc - last, 800);
        last = cyc;
        nls++;
      end
    end
    chk("a_hsync_low_cycles", hs_low, 192);
    chk("a_new_line_count_full", nls, 2);

    // half rate: tick on every 2nd clk
    nls = 0;
    last = -1;
    cyc = 0;
    for (int i = 0; i < 3200; i++) begin
      step((i % 2) == 1, 1'($urandom));
      cyc++;
      if (bus_a.new_line === 1'b1) begin
        if (last >= 0) chk("a_line_period_half", cyc - last, 1600);
        last = cyc;
        nls++;
      end
    end
    chk("a_new_line_count_half", nls, 2);

    // walk A to (300, 4), then reset between clock edges
    for (int i = 0; i < 1000 && pos[0] != 3500; i++) begin
      step(1'b1, 1'($urandom));
    end
    chk("a_pre_rst_h", 32'(bus_a.h_count), 300);
    chk("a_pre_rst_v", 32'(bus_a.v_count), 4);
    #2;
    rst = 1'b1;
    #1;
    mdl_reset(0);
    mdl_reset(1);
    check_all();
    chk("a_async_rst_h", 32'(bus_a.h_count), 799);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("a_post_rst_h", 32'(bus_a.h_count), 0);
    chk("a_post_rst_v", 32'(bus_a.v_count), 0);
    chk("a_post_rst_frame", 32'(bus_a.new_frame), 1);

    for (int i = 0; i < 200; i++) begin
      step(1'($urandom), 1'($urandom));
    end
    chk("b_frames_seen", 32'(frames_b >= 2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
